// File: rtl/shift_counter_pkg.sv
// Shared mode encoding for the shift-register counter and its prescaler.
package shift_counter_pkg;

  typedef enum logic [1:0] {
    MODE_JOHNSON = 2'b00,
    MODE_RING    = 2'b01,
    MODE_BINARY  = 2'b10,
    MODE_HOLD    = 2'b11
  } mode_t;

endpackage

// File: rtl/tick_prescaler.sv
// Enable-gated prescaler: one tick per prescale+1 enabled cycles, cleared by load.
module tick_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] pre_cnt_reg;

  // >= rather than == so a prescale lowered below the running count still fires
  assign tick = en && (pre_cnt_reg >= prescale);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_reg <= '0;
    end else if (clear) begin
      pre_cnt_reg <= '0;
    end else if (en) begin
      pre_cnt_reg <= tick ? '0 : pre_cnt_reg + PRESCALE_W'(1);
    end
  end

endmodule

// File: rtl/shift_counter_gen.sv
// Johnson / ring / binary counter with prescaler, parallel load and illegal-state recovery.
module shift_counter_gen
  import shift_counter_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic                  dir,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  wrap,
  output logic                  illegal
);

  logic [WIDTH-1:0] count_reg, count_next;
  logic             wrap_reg, wrap_next;
  logic             illegal_reg, illegal_next;
  logic             tick;
  logic [WIDTH-1:0] seed;
  logic [WIDTH-1:0] stepped;
  logic [WIDTH-2:0] j_edges;
  logic             j_legal, r_legal, legal;
  mode_t            mode_sel;

  assign mode_sel = mode_t'(mode);

  tick_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_pre (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .clear    (load),
    .prescale (prescale),
    .tick     (tick)
  );

  // A legal Johnson word has at most one boundary between adjacent bits
  for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_edges
    assign j_edges[gi] = count_reg[gi] ^ count_reg[gi+1];
  end

  assign j_legal = (j_edges & (j_edges - (WIDTH-1)'(1))) == '0;
  assign r_legal = (count_reg != '0) && ((count_reg & (count_reg - WIDTH'(1))) == '0);

  always_comb begin
    seed    = (mode_sel == MODE_RING) ? WIDTH'(1) : '0;
    stepped = count_reg;
    legal   = 1'b1;
    case (mode_sel)
      MODE_JOHNSON: begin
        stepped = dir ? {~count_reg[0], count_reg[WIDTH-1:1]}
                      : {count_reg[WIDTH-2:0], ~count_reg[WIDTH-1]};
        legal   = j_legal;
      end
      MODE_RING: begin
        stepped = dir ? {count_reg[0], count_reg[WIDTH-1:1]}
                      : {count_reg[WIDTH-2:0], count_reg[WIDTH-1]};
        legal   = r_legal;
      end
      MODE_BINARY: begin
        stepped = dir ? count_reg - WIDTH'(1) : count_reg + WIDTH'(1);
      end
      default: begin
        stepped = count_reg;
      end
    endcase
  end

  always_comb begin
    count_next   = count_reg;
    wrap_next    = 1'b0;
    illegal_next = 1'b0;
    if (load) begin
      count_next = load_val;
    end else if (tick && (mode_sel != MODE_HOLD)) begin
      if (!legal) begin
        count_next   = seed;
        illegal_next = 1'b1;
      end else begin
        count_next = stepped;
        wrap_next  = (stepped == seed);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg   <= '0;
      wrap_reg    <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      count_reg   <= count_next;
      wrap_reg    <= wrap_next;
      illegal_reg <= illegal_next;
    end
  end

  assign count   = count_reg;
  assign wrap    = wrap_reg;
  assign illegal = illegal_reg;

endmodule

// File: tb/tb_shift_counter_gen.sv
// Randomised and directed checks of shift_counter_gen against a sequence-table reference model.
module tb_shift_counter_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       dir = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [7:0] prescale = 8'h00;
  logic [7:0] count;
  logic       wrap;
  logic       illegal;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_count = 8'h00;
  logic       exp_wrap = 1'b0;
  logic       exp_ill = 1'b0;
  int         exp_pre = 0;

  shift_counter_gen #(.WIDTH(8), .PRESCALE_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .mode     (mode),
    .dir      (dir),
    .load     (load),
    .load_val (load_val),
    .prescale (prescale),
    .count    (count),
    .wrap     (wrap),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  // k-th word of the 16-state Johnson cycle as seen stepping left from 00
  function automatic logic [7:0] johnson_state(int k);
    logic [15:0] t;
    if (k <= 8) t = (16'd1 << k) - 16'd1;
    else        t = 16'h00FF << (k - 8);
    return t[7:0];
  endfunction

  function automatic void model_step();
    logic [7:0] seed, nxt;
    logic       tk;
    int         idx;
    exp_wrap = 1'b0;
    exp_ill  = 1'b0;
    if (load) begin
      exp_count = load_val;
      exp_pre   = 0;
      return;
    end
    tk = en && (exp_pre >= int'(prescale));
    if (en) exp_pre = tk ? 0 : exp_pre + 1;
    if (!tk || mode == 2'b11) return;
    seed = (mode == 2'b01) ? 8'h01 : 8'h00;
    idx  = -1;
    nxt  = 8'h00;
    case (mode)
      2'b00: begin
        for (int k = 0; k < 16; k++) if (johnson_state(k) == exp_count) idx = k;
        if (idx >= 0) nxt = johnson_state(dir ? (idx + 15) % 16 : (idx + 1) % 16);
      end
      2'b01: begin
        for (int k = 0; k < 8; k++) if (8'(1 << k) == exp_count) idx = k;
        if (idx >= 0) nxt = 8'(1 << (dir ? (idx + 7) % 8 : (idx + 1) % 8));
      end
      default: begin
        idx = 0;
        nxt = dir ? exp_count - 8'd1 : exp_count + 8'd1;
      end
    endcase
    if (idx < 0) begin
      exp_count = seed;
      exp_ill   = 1'b1;
    end else begin
      exp_wrap  = (nxt == seed);
      exp_count = nxt;
    end
  endfunction

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    load  = 1'b0;
    en    = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    exp_count = 8'h00;
    exp_wrap  = 1'b0;
    exp_ill   = 1'b0;
    exp_pre   = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({count, wrap, illegal} !== 10'h000) begin
      n_err++;
      $display("FAIL reset: got count=%h wrap=%b illegal=%b, expected 00 0 0", count, wrap, illegal);
    end
    do_reset();
  endtask

  task automatic test_johnson();
    do_reset();
    mode = 2'b00; dir = 1'b0; prescale = 8'd0; en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      cyc();
      n_cmp++;
      if ({count, wrap, illegal} !== {exp_count, exp_wrap, exp_ill} || wrap !== (i == 16)) begin
        n_err++;
        $display("FAIL johnson step %0d: got %h/%b/%b expected %h/%b/%b", i, count, wrap, illegal,
                 exp_count, exp_wrap, exp_ill);
      end
    end
    $display("johnson: 16 steps ended at count=%h", count);
  endtask

  task automatic test_ring();
    do_reset();
    mode = 2'b01; dir = 1'b1; prescale = 8'd0; en = 1'b1;
    cyc();
    n_cmp++;
    if (count !== 8'h01 || illegal !== 1'b1 || wrap !== 1'b0) begin
      n_err++;
      $display("FAIL ring first tick: got %h/%b/%b expected 01/0/1", count, wrap, illegal);
    end
    for (int i = 1; i <= 16; i++) begin
      cyc();
      n_cmp++;
      if ({count, wrap, illegal} !== {exp_count, exp_wrap, exp_ill} || wrap !== (i % 8 == 0)) begin
        n_err++;
        $display("FAIL ring step %0d: got %h/%b/%b expected %h/%b/%b", i, count, wrap, illegal,
                 exp_count, exp_wrap, exp_ill);
      end
    end
    $display("ring: 16 right rotations ended at count=%h", count);
  endtask

  task automatic test_load_illegal();
    mode = 2'b00; dir = 1'b0; prescale = 8'd0; en = 1'b1;
    load = 1'b1; load_val = 8'hA5;
    cyc();
    load = 1'b0;
    n_cmp++;
    if (count !== 8'hA5 || wrap !== 1'b0 || illegal !== 1'b0) begin
      n_err++;
      $display("FAIL load A5: got %h/%b/%b expected a5/0/0", count, wrap, illegal);
    end
    cyc();
    n_cmp++;
    if (count !== 8'h00 || wrap !== 1'b0 || illegal !== 1'b1) begin
      n_err++;
      $display("FAIL johnson correct: got %h/%b/%b expected 00/0/1", count, wrap, illegal);
    end
    $display("load_illegal: corrected to count=%h illegal=%b", count, illegal);
  endtask

  task automatic test_binary_down();
    mode = 2'b10; dir = 1'b1; prescale = 8'd3; en = 1'b1;
    load = 1'b1; load_val = 8'h01;
    cyc();
    load = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      cyc();
      n_cmp++;
      if ({count, wrap, illegal} !== {exp_count, exp_wrap, exp_ill}) begin
        n_err++;
        $display("FAIL binary down cycle %0d: got %h/%b/%b expected %h/%b/%b", i, count, wrap,
                 illegal, exp_count, exp_wrap, exp_ill);
      end
      if (i == 4 || i == 8) begin
        n_cmp++;
        if (count !== ((i == 4) ? 8'h00 : 8'hFF) || wrap !== (i == 4)) begin
          n_err++;
          $display("FAIL binary down boundary %0d: got %h wrap=%b", i, count, wrap);
        end
      end
    end
    $display("binary_down: 01 -> 00 (wrap) -> ff (no wrap), count=%h", count);
  endtask

  task automatic test_prescale_drop();
    mode = 2'b10; dir = 1'b0; prescale = 8'd9; en = 1'b1;
    load = 1'b1; load_val = 8'h00;
    cyc();
    load = 1'b0;
    repeat (5) cyc();
    prescale = 8'd2;
    cyc();
    n_cmp++;
    if (count !== 8'h01) begin
      n_err++;
      $display("FAIL prescale drop: got count=%h expected 01", count);
    end
    for (int i = 1; i <= 9; i++) begin
      cyc();
      n_cmp++;
      if ({count, wrap, illegal} !== {exp_count, exp_wrap, exp_ill} || count !== 8'(1 + i / 3)) begin
        n_err++;
        $display("FAIL prescale 2 cycle %0d: got %h expected %h", i, count, exp_count);
      end
    end
    $display("prescale_drop: count=%h after lowering prescale", count);
  endtask

  task automatic test_en_freeze();
    mode = 2'b10; dir = 1'b0; prescale = 8'd4; en = 1'b1;
    load = 1'b1; load_val = 8'h10;
    cyc();
    load = 1'b0;
    repeat (2) cyc();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      load     = (i == 3);
      load_val = 8'h77;
      cyc();
      n_cmp++;
      if (count !== ((i >= 3) ? 8'h77 : 8'h10) || wrap !== 1'b0 || illegal !== 1'b0) begin
        n_err++;
        $display("FAIL en low cycle %0d: got %h expected %h", i, count, (i >= 3) ? 8'h77 : 8'h10);
      end
    end
    load = 1'b0;
    en   = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      n_cmp++;
      if ({count, wrap, illegal} !== {exp_count, exp_wrap, exp_ill}) begin
        n_err++;
        $display("FAIL en resume cycle %0d: got %h expected %h", i, count, exp_count);
      end
    end
    $display("en_freeze: count=%h after resume", count);
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) dir = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 31) == 0) prescale = 8'($urandom_range(0, 3));
      en       = ($urandom_range(0, 9) < 8);
      load     = ($urandom_range(0, 29) == 0);
      load_val = 8'($urandom);
      cyc();
      n_cmp++;
      if ({count, wrap, illegal} !== {exp_count, exp_wrap, exp_ill} || (wrap && illegal)) begin
        n_err++;
        bad++;
        $display("FAIL random cycle %0d mode=%0d dir=%b: got %h/%b/%b expected %h/%b/%b", i, mode,
                 dir, count, wrap, illegal, exp_count, exp_wrap, exp_ill);
      end
    end
    load = 1'b0;
    $display("random: 600 cycles, %0d bad", bad);
  endtask

  task automatic test_async_reset();
    do_reset();
    mode = 2'b00; dir = 1'b0; prescale = 8'd0; en = 1'b1;
    repeat (5) cyc();
    n_cmp++;
    if (count !== 8'h1F) begin
      n_err++;
      $display("FAIL pre-reset count: got %h expected 1f", count);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({count, wrap, illegal} !== 10'h000) begin
      n_err++;
      $display("FAIL async reset: got %h/%b/%b expected 00/0/0", count, wrap, illegal);
    end
    $display("async_reset: count=%h while rst_n low", count);
    do_reset();
  endtask

  initial begin
    test_reset();
    test_johnson();
    test_ring();
    test_load_illegal();
    test_binary_down();
    test_prescale_drop();
    test_en_freeze();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
